// File: rtl/hack_ram_pkg.sv
// Shared types and Hack memory-map defaults for the parametrised RAM.
// The post-reset clear sequencer is enabled by defining HACK_RAM_CLEAR_EN.
package hack_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   // RAM16K data region and the memory-mapped screen
   localparam int RAM16K_WIDTH  = 16;
   localparam int RAM16K_ADDR_W = 14;
   localparam int SCREEN_WIDTH  = 16;
   localparam int SCREEN_ADDR_W = 13;

endpackage

// File: rtl/hack_ram_if.sv
// CPU-side data bus of the Hack RAM: write data, load strobe, address,
// registered read data, ready and out-of-range flag.
interface hack_ram_if
   import hack_ram_pkg::*;
#(
   parameter int WIDTH  = RAM16K_WIDTH,
   parameter int ADDR_W = RAM16K_ADDR_W
);
   logic [WIDTH-1:0]  in;
   logic              load;
   logic [ADDR_W-1:0] address;
   logic [WIDTH-1:0]  out;
   logic              ready;
   logic              err;

   modport master (output in, load, address, input out, ready, err);
   modport slave  (input in, load, address, output out, ready, err);
endinterface

// File: rtl/hack_ram_array.sv
// Plain storage: synchronous write, combinational read, no reset.
module hack_ram_array #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/hack_ram.sv
// Parametrised Hack RAM: registered read with write-first forwarding,
// out-of-range flagging, and an optional clear sequencer (HACK_RAM_CLEAR_EN).
module hack_ram
   import hack_ram_pkg::*;
#(
   parameter int WIDTH  = RAM16K_WIDTH,
   parameter int ADDR_W = RAM16K_ADDR_W,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic      clk,
   input  logic      rst_n,
   hack_ram_if.slave bus
);
   // One extra bit so DEPTH == 2**ADDR_W is representable and never flags
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic              in_range;
   logic              running;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  rdata;
   logic [WIDTH-1:0]  out_reg;
   logic              err_reg;

   assign in_range = {1'b0, bus.address} < DEPTH_EXT;

`ifdef HACK_RAM_CLEAR_EN
   localparam logic [0:0]        S_CLEAR  = 1'(CLEAR);
   localparam logic [0:0]        S_RUN    = 1'(RUN);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   logic [0:0]        state_reg;
   logic [ADDR_W-1:0] clr_ptr_reg;
   logic              clearing;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_CLEAR;
         clr_ptr_reg <= '0;
      end else if (state_reg == S_CLEAR) begin
         clr_ptr_reg <= clr_ptr_reg + 1'b1;
         if (clr_ptr_reg == LAST_PTR) begin
            state_reg <= S_RUN;
         end
      end
   end

   assign clearing = (state_reg == S_CLEAR);
   assign running  = (state_reg == S_RUN);
   // The sequencer owns the write port while clearing; bus traffic is ignored
   assign we       = clearing | (bus.load & in_range);
   assign waddr    = clearing ? clr_ptr_reg : bus.address;
   assign wdata    = clearing ? '0 : bus.in;
`else
   assign running  = 1'b1;
   assign we       = bus.load & in_range;
   assign waddr    = bus.address;
   assign wdata    = bus.in;
`endif

   hack_ram_array #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (bus.address),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= '0;
         err_reg <= 1'b0;
      end else if (!running) begin
         out_reg <= '0;
         err_reg <= 1'b0;
      end else if (!in_range) begin
         out_reg <= '0;
         err_reg <= 1'b1;
      end else begin
         out_reg <= bus.load ? bus.in : rdata;
         err_reg <= 1'b0;
      end
   end

   assign bus.out   = out_reg;
   assign bus.err   = err_reg;
   assign bus.ready = running;
endmodule

// File: tb/tb_hack_ram.sv
// Bench for hack_ram: two instances (DEPTH=8/ADDR_W=3 and DEPTH=12/ADDR_W=4)
// driven together and compared against an array-based reference model.
module tb_hack_ram;
`ifdef HACK_RAM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hack_ram_if #(.WIDTH(16), .ADDR_W(3)) b8 ();
   hack_ram_if #(.WIDTH(16), .ADDR_W(4)) b12 ();

   hack_ram #(.WIDTH(16), .ADDR_W(3), .DEPTH(8)) u8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8)
   );

   hack_ram #(.WIDTH(16), .ADDR_W(4), .DEPTH(12)) u12 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b12)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_step   = 0;

   // Reference model: index 0 is the DEPTH=8 instance, 1 the DEPTH=12 one
   int          depth_m [2] = '{8, 12};
   logic [15:0] mem_m   [2][16];
   bit          known_m [2][16];
   int          edges_m [2];

   function automatic bit ready_m(input int u);
      return !CLR || (edges_m[u] >= depth_m[u]);
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         edges_m[u] = 0;
         if (CLR) begin
            for (int i = 0; i < 16; i++) begin
               mem_m[u][i]   = 16'h0;
               known_m[u][i] = 1'b1;
            end
         end
      end
   endtask

   task automatic model_edge(input int u, input bit l, input int a, input logic [15:0] d,
                             output logic [15:0] eo, output bit ee, output bit ek);
      eo = 16'h0;
      ee = 1'b0;
      ek = 1'b1;
      if (ready_m(u)) begin
         if (a >= depth_m[u]) begin
            ee = 1'b1;
         end else if (l) begin
            mem_m[u][a]   = d;
            known_m[u][a] = 1'b1;
            eo            = d;
         end else begin
            eo = mem_m[u][a];
            ek = known_m[u][a];
         end
      end
      edges_m[u]++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out8"},    32'(b8.out),    32'h0);
      check({tag, "_err8"},    32'(b8.err),    32'h0);
      check({tag, "_ready8"},  32'(b8.ready),  32'(!CLR));
      check({tag, "_out12"},   32'(b12.out),   32'h0);
      check({tag, "_err12"},   32'(b12.err),   32'h0);
      check({tag, "_ready12"}, 32'(b12.ready), 32'(!CLR));
   endtask

   // One clock edge on both instances, then compare every output
   task automatic step(input bit l0, input int a0, input logic [15:0] d0,
                       input bit l1, input int a1, input logic [15:0] d1);
      logic [15:0] eo [2];
      bit          ee [2];
      bit          ek [2];
      b8.load     = l0;
      b8.address  = 3'(a0);
      b8.in       = d0;
      b12.load    = l1;
      b12.address = 4'(a1);
      b12.in      = d1;
      model_edge(0, l0, a0, d0, eo[0], ee[0], ek[0]);
      model_edge(1, l1, a1, d1, eo[1], ee[1], ek[1]);
      @(posedge clk);
      #1;
      n_step++;
      $display("step %0d: r8 l=%0b a=%0d d=%h -> out=%h err=%0b rdy=%0b | r12 l=%0b a=%0d d=%h -> out=%h err=%0b rdy=%0b",
               n_step, l0, a0, d0, b8.out, b8.err, b8.ready, l1, a1, d1, b12.out, b12.err, b12.ready);
      if (ek[0]) check($sformatf("s%0d_out8", n_step), 32'(b8.out), 32'(eo[0]));
      if (ek[1]) check($sformatf("s%0d_out12", n_step), 32'(b12.out), 32'(eo[1]));
      check($sformatf("s%0d_err8", n_step),    32'(b8.err),    32'(ee[0]));
      check($sformatf("s%0d_err12", n_step),   32'(b12.err),   32'(ee[1]));
      check($sformatf("s%0d_ready8", n_step),  32'(b8.ready),  32'(ready_m(0)));
      check($sformatf("s%0d_ready12", n_step), 32'(b12.ready), 32'(ready_m(1)));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 16'h0, 1'b0, 0, 16'h0);
   endtask

   initial begin
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < 16; i++) begin
            mem_m[u][i]   = 16'h0;
            known_m[u][i] = 1'b0;
         end
      b8.load = 1'b0;  b8.address = '0;  b8.in = '0;
      b12.load = 1'b0; b12.address = '0; b12.in = '0;
      model_reset();

      // Reset values, then release between edges
      #3;
      check_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Clear phase with loads to address 1 in the first cycles
      for (int k = 1; k <= 12; k++) begin
         if (k <= 3) step(1'b1, 1, 16'h0009, 1'b1, 1, 16'h0009);
         else        idle_steps(1);
      end

      // Read back every word
      for (int i = 0; i < 12; i++) step(1'b0, i % 8, 16'h0, 1'b0, i, 16'h0);

      // Write then read, neighbour untouched
      step(1'b1, 5, 16'h0003, 1'b0, 0, 16'h0);
      step(1'b0, 5, 16'h0000, 1'b0, 0, 16'h0);
      step(1'b0, 4, 16'h0000, 1'b0, 0, 16'h0);

      // Back-to-back write-first
      step(1'b1, 2, 16'hAAAA, 1'b1, 2, 16'hAAAA);
      step(1'b1, 3, 16'h5555, 1'b1, 3, 16'h5555);
      step(1'b0, 2, 16'h0000, 1'b0, 2, 16'h0000);
      step(1'b0, 3, 16'h0000, 1'b0, 3, 16'h0000);

      // Out-of-range on the DEPTH=12 instance
      step(1'b0, 0, 16'h0, 1'b1, 13, 16'h0007);
      step(1'b0, 0, 16'h0, 1'b0, 11, 16'h0000);
      step(1'b0, 0, 16'h0, 1'b0, 13, 16'h0000);
      step(1'b0, 0, 16'h0, 1'b0, 12, 16'h0000);
      step(1'b0, 0, 16'h0, 1'b1, 11, 16'h1234);
      step(1'b0, 0, 16'h0, 1'b1, 15, 16'hFFFF);
      step(1'b0, 0, 16'h0, 1'b0, 11, 16'h0000);

      // Randomised traffic
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 16'($urandom));
      end

      // Asynchronous reset mid-run with non-zero output
      step(1'b1, 6, 16'hBEEF, 1'b1, 6, 16'hBEEF);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("midrun_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Asynchronous reset mid-clear, then a full restart
      idle_steps(4);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("midclear_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         if (k == 2) step(1'b1, 1, 16'h0009, 1'b1, 1, 16'h0009);
         else        idle_steps(1);
      end
      for (int i = 0; i < 12; i++) step(1'b0, i % 8, 16'h0, 1'b0, i, 16'h0);

      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
